// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
// Holds the state encoding, the counter width helper and the width ceiling.
package serial_add_ctrl_pkg;

  localparam int WIDTH_MAX = 64;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_add_ctrl.sv
// Drives an external full-adder cell LSB first to form a WIDTH-bit add; done pulses WIDTH+1 edges after start.
// start is only sampled in IDLE, so requests made while busy are dropped.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_i0,
  output logic             fa_i1,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_areg;
  logic [WIDTH-1:0] r_breg;
  logic [WIDTH-1:0] r_sreg;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_run;
  logic             w_last;
  logic [WIDTH-1:0] w_sreg_nxt;

  assign w_run  = (r_state == ST_RUN);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Written bit-wise so a one-bit register needs no special-case slice.
  always_comb begin
    w_sreg_nxt            = r_sreg >> 1;
    w_sreg_nxt[WIDTH-1]   = fa_s;
  end

  // The adder sees registered bits only; operands on a/b never reach it directly.
  assign fa_i0 = w_run & r_areg[0];
  assign fa_i1 = w_run & r_breg[0];
  assign fa_ci = w_run & r_carry;

  assign busy = w_run | (r_state == ST_DONE);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_areg  <= '0;
      r_breg  <= '0;
      r_sreg  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_areg  <= a;
            r_breg  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sreg  <= w_sreg_nxt;
          r_carry <= fa_co;
          r_areg  <= r_areg >> 1;
          r_breg  <= r_breg >> 1;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum   <= w_sreg_nxt;
            r_cout  <= fa_co;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
